// File: rtl/regfile_mp_ctx.sv
// Multi-port register file with same-cycle write bypass on reads and a one-register-per-beat context save/restore engine.
// Reads are combinational (zero-cycle latency); a context op stalls in place while its stream withholds a handshake.
module regfile_mp_ctx #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 8,
  parameter int NWR  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR*$clog2(NREG)-1:0] wr_addr,
  input  logic [NWR*XLEN-1:0]      wr_data,
  input  logic [NRD*$clog2(NREG)-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]      rd_data,
  input  logic                     ctx_cmd_valid,
  input  logic                     ctx_cmd_save,
  output logic                     ctx_cmd_ready,
  output logic                     ctx_out_valid,
  input  logic                     ctx_out_ready,
  output logic [$clog2(NREG)-1:0]  ctx_out_idx,
  output logic [XLEN-1:0]          ctx_out_data,
  input  logic                     ctx_in_valid,
  output logic                     ctx_in_ready,
  input  logic [XLEN-1:0]          ctx_in_data,
  output logic                     ctx_busy,
  output logic                     ctx_done
);
  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SAVE    = 2'd1;
  localparam logic [1:0] ST_RESTORE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [XLEN-1:0] regs [NREG];
  logic [1:0]      state;
  logic [AW-1:0]   idx;
  logic [NWR-1:0]  wr_act;
  logic            rs_fire;

  assign ctx_busy      = (state != ST_IDLE);
  assign ctx_cmd_ready = (state == ST_IDLE);
  assign ctx_done      = (state == ST_DONE);
  assign ctx_out_valid = (state == ST_SAVE);
  assign ctx_in_ready  = (state == ST_RESTORE);
  assign ctx_out_idx   = idx;
  assign ctx_out_data  = regs[idx];
  assign wr_act        = wr_en & {NWR{~ctx_busy}};
  assign rs_fire       = ctx_in_ready & ctx_in_valid;

  // Later ports overwrite earlier ones, so the youngest write to an address wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_act[k] && (wr_addr[k*AW +: AW] != '0))
          regs[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
      end
      if (rs_fire) regs[idx] <= ctx_in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= AW'(1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctx_cmd_valid) begin
            state <= ctx_cmd_save ? ST_SAVE : ST_RESTORE;
            idx   <= AW'(1);
          end
        end
        ST_SAVE: begin
          if (ctx_out_ready) begin
            if (idx == LAST_IDX) state <= ST_DONE;
            else                 idx   <= idx + AW'(1);
          end
        end
        ST_RESTORE: begin
          if (rs_fire) begin
            if (idx == LAST_IDX) state <= ST_DONE;
            else                 idx   <= idx + AW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Restore writes are deliberately absent from the bypass; they show up next cycle.
  always_comb begin
    logic [XLEN-1:0] rv;
    rv      = '0;
    rd_data = '0;
    for (int p = 0; p < NRD; p++) begin
      rv = regs[rd_addr[p*AW +: AW]];
      for (int k = 0; k < NWR; k++) begin
        if (wr_act[k] && (wr_addr[k*AW +: AW] == rd_addr[p*AW +: AW]))
          rv = wr_data[k*XLEN +: XLEN];
      end
      if (rd_addr[p*AW +: AW] == '0) rv = '0;
      rd_data[p*XLEN +: XLEN] = rv;
    end
  end

endmodule

// File: tb/tb_regfile_mp_ctx.sv
// Scoreboard bench for regfile_mp_ctx: expected reads and save beats are queued at drive time and checked at negedge.
module tb_regfile_mp_ctx;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 8;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                 clk;
  logic                 reset;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*XLEN-1:0]  wr_data;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic                 ctx_cmd_valid, ctx_cmd_save, ctx_cmd_ready;
  logic                 ctx_out_valid, ctx_out_ready;
  logic [AW-1:0]        ctx_out_idx;
  logic [XLEN-1:0]      ctx_out_data;
  logic                 ctx_in_valid, ctx_in_ready;
  logic [XLEN-1:0]      ctx_in_data;
  logic                 ctx_busy, ctx_done;

  regfile_mp_ctx #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .ctx_cmd_valid(ctx_cmd_valid), .ctx_cmd_save(ctx_cmd_save), .ctx_cmd_ready(ctx_cmd_ready),
    .ctx_out_valid(ctx_out_valid), .ctx_out_ready(ctx_out_ready),
    .ctx_out_idx(ctx_out_idx), .ctx_out_data(ctx_out_data),
    .ctx_in_valid(ctx_in_valid), .ctx_in_ready(ctx_in_ready), .ctx_in_data(ctx_in_data),
    .ctx_busy(ctx_busy), .ctx_done(ctx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  logic [XLEN-1:0]    mdl [NREG];
  logic               mdl_busy;
  logic               mdl_rs;
  int                 rs_idx;
  logic [XLEN-1:0]    rd_q [$];
  logic [AW+XLEN-1:0] sv_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] mdl_read(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    v = mdl[a];
    if (!mdl_busy)
      for (int k = 0; k < NWR; k++)
        if (wr_en[k] && wr_addr[k*AW +: AW] == a) v = wr_data[k*XLEN +: XLEN];
    if (a == '0) v = '0;
    return v;
  endfunction

  // One clock of traffic: inputs already driven at posedge+1.
  task automatic step(input string tag);
    for (int p = 0; p < NRD; p++) rd_q.push_back(mdl_read(rd_addr[p*AW +: AW]));
    @(negedge clk);
    for (int p = 0; p < NRD; p++) chk({tag, "_rd"}, rd_data[p*XLEN +: XLEN], rd_q.pop_front());
    chk({tag, "_busy"}, ctx_busy, mdl_busy);
    chk({tag, "_cmd_rdy"}, ctx_cmd_ready, !mdl_busy);
    chk({tag, "_in_rdy"}, ctx_in_ready, mdl_rs);
    if (!mdl_busy) chk({tag, "_out_vld"}, ctx_out_valid, 1'b0);
    if (ctx_done) n_done++;
    if (ctx_out_valid) begin
      if (sv_q.size() == 0) chk({tag, "_sv_extra"}, 1'b1, 1'b0);
      else begin
        chk({tag, "_sv_beat"}, {ctx_out_idx, ctx_out_data}, sv_q[0]);
        if (ctx_out_ready) void'(sv_q.pop_front());
      end
    end
    if (reset) begin
      for (int r = 0; r < NREG; r++) mdl[r] = '0;
    end else begin
      if (!mdl_busy)
        for (int k = 0; k < NWR; k++)
          if (wr_en[k] && wr_addr[k*AW +: AW] != '0)
            mdl[wr_addr[k*AW +: AW]] = wr_data[k*XLEN +: XLEN];
      if (mdl_rs && ctx_in_valid) mdl[rs_idx] = ctx_in_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic read_all(input string tag);
    for (int j = 0; j < NREG / NRD; j++) begin
      for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = AW'(j*NRD + p);
      step(tag);
    end
  endtask

  task automatic rand_wr();
    wr_en = NWR'($urandom);
    for (int k = 0; k < NWR; k++) begin
      wr_addr[k*AW +: AW]   = AW'($urandom_range(0, NREG-1));
      wr_data[k*XLEN +: XLEN] = $urandom;
    end
  endtask

  initial begin
    int d0;
    for (int r = 0; r < NREG; r++) mdl[r] = '0;
    mdl_busy = 0; mdl_rs = 0; rs_idx = 1;
    reset = 1; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    ctx_cmd_valid = 0; ctx_cmd_save = 0; ctx_out_ready = 0; ctx_in_valid = 0; ctx_in_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    // Reset state
    for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = AW'(p + 3);
    step("rst");
    chk("rst_done", n_done, 0);

    // Two ports write x5 in one cycle: the younger port wins, bypass and after edge
    wr_en = 2'b11;
    wr_addr = {AW'(5), AW'(5)};
    wr_data = {32'h22, 32'h11};
    rd_addr = '0;
    for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = AW'(5);
    step("t1_byp");
    wr_en = '0;
    step("t1_after");
    @(negedge clk);
    chk("t1_x5", rd_data[XLEN-1:0], 32'h22);
    @(posedge clk); #1;

    // Writes to x0 are discarded
    wr_en = 2'b11;
    wr_addr = '0;
    wr_data = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    rd_addr = '0;
    step("t2_x0");
    wr_en = '0;
    step("t2_x0_after");

    // Load x1..x31 = i*0x101, two per cycle
    for (int c = 0; c < 16; c++) begin
      wr_en = (c < 15) ? 2'b11 : 2'b01;
      wr_addr[0 +: AW]  = AW'(2*c + 1);
      wr_addr[AW +: AW] = AW'(2*c + 2);
      wr_data[0 +: XLEN]    = (2*c + 1) * 32'h101;
      wr_data[XLEN +: XLEN] = (2*c + 2) * 32'h101;
      step("t3_load");
    end
    wr_en = '0;

    // Save with toggling out_ready
    for (int i = 1; i < NREG; i++) sv_q.push_back({AW'(i), i * 32'h101});
    n_done = 0;
    ctx_cmd_valid = 1; ctx_cmd_save = 1;
    step("t3_cmd");
    ctx_cmd_valid = 0;
    mdl_busy = 1;
    for (int c = 0; c < 200 && n_done == 0; c++) begin
      ctx_out_ready = c[0];
      rand_wr();
      for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, NREG-1));
      step("t3_save");
    end
    wr_en = '0; ctx_out_ready = 0;
    mdl_busy = 0;
    chk("t3_beats_left", sv_q.size(), 0);
    chk("t3_done_cnt", n_done, 1);
    step("t3_idle");
    chk("t3_done_cnt_after", n_done, 1);
    read_all("t3_regs");

    // Restore with writes attempted throughout the busy window
    n_done = 0;
    ctx_cmd_valid = 1; ctx_cmd_save = 0;
    step("t4_cmd");
    ctx_cmd_valid = 0;
    mdl_busy = 1; mdl_rs = 1;
    for (int i = 1; i < NREG; i++) begin
      rs_idx = i;
      ctx_in_valid = 1;
      ctx_in_data = 32'hA000_0000 + i;
      rand_wr();
      for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, NREG-1));
      step("t4_rs");
    end
    ctx_in_valid = 0; mdl_rs = 0;
    step("t4_done");
    chk("t4_done_cnt", n_done, 1);
    wr_en = '0; mdl_busy = 0;
    read_all("t4_regs");
    chk("t4_done_cnt_after", n_done, 1);

    // Reset at restore beat 10
    n_done = 0;
    ctx_cmd_valid = 1; ctx_cmd_save = 0;
    step("t5_cmd");
    ctx_cmd_valid = 0;
    mdl_busy = 1; mdl_rs = 1;
    for (int i = 1; i <= 10; i++) begin
      rs_idx = i;
      ctx_in_valid = 1;
      ctx_in_data = 32'h5500_0000 + i;
      reset = (i == 10);
      step("t5_rs");
    end
    reset = 0; ctx_in_valid = 1; mdl_busy = 0; mdl_rs = 0;
    step("t5_post");
    ctx_in_valid = 0;
    read_all("t5_regs");
    chk("t5_no_done", n_done, 0);

    // Random multi-port traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rand_wr();
      for (int p = 0; p < NRD; p++) begin
        d0 = $urandom_range(0, 3);
        if (d0 < NWR) rd_addr[p*AW +: AW] = wr_addr[d0*AW +: AW];
        else          rd_addr[p*AW +: AW] = AW'($urandom_range(0, NREG-1));
      end
      step("t6_rnd");
    end
    wr_en = '0;
    read_all("t6_regs");
    chk("t6_no_done", n_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
